// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that shares one single-command SDRAM controller port between
// several requesters, tracking read bursts and aborting stalled transactions.
module sdram_port_arbiter #(
    parameter int NUM_PORTS         = 2,
    parameter int READ_BURST_LENGTH = 1,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_PORTS-1:0]      port_request,
    input  logic [NUM_PORTS-1:0]      port_write,
    input  logic [22*NUM_PORTS-1:0]   port_address,
    input  logic [16*NUM_PORTS-1:0]   port_data_write,
    output logic [NUM_PORTS-1:0]      port_grant,
    output logic [15:0]               port_data_read,
    output logic [NUM_PORTS-1:0]      port_data_read_valid,
    output logic [NUM_PORTS-1:0]      port_data_write_done,
    output logic                      timeout_error,
    output logic [1:0]                command,
    output logic [21:0]               data_address,
    output logic [15:0]               data_write,
    input  logic [15:0]               data_read,
    input  logic                      data_read_valid,
    input  logic                      data_write_done,
    output logic [1:0]                fsm_state
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_READ  = 2'd2,
        WAIT_WRITE = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   winner, rr_ptr, pick, hi_pick, lo_pick;
    logic            hi_valid, pick_valid, pick_write, is_write;
    logic [21:0]     pick_address;
    logic [15:0]     pick_data;
    logic [8:0]      beat_cnt;
    logic [TW-1:0]   wait_cnt;
    logic            in_wait, last_beat, write_end, timed_out;

    // First requester at or above rr_ptr wins; otherwise wrap to the lowest requester.
    always_comb begin
        hi_pick    = '0;
        lo_pick    = '0;
        hi_valid   = 1'b0;
        pick_valid = |port_request;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (port_request[j]) begin
                lo_pick = PW'(j);
                if (PW'(j) >= rr_ptr) begin
                    hi_pick  = PW'(j);
                    hi_valid = 1'b1;
                end
            end
        end
        pick = hi_valid ? hi_pick : lo_pick;
    end

    always_comb begin
        pick_write   = 1'b0;
        pick_address = '0;
        pick_data    = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (pick == PW'(j)) begin
                pick_write   = port_write[j];
                pick_address = port_address[22*j +: 22];
                pick_data    = port_data_write[16*j +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // A completion arriving on the final timeout cycle wins over the abort.
    always_comb begin
        in_wait    = (state == WAIT_READ) || (state == WAIT_WRITE);
        last_beat  = (state == WAIT_READ) && data_read_valid &&
                     (beat_cnt == 9'(READ_BURST_LENGTH - 1));
        write_end  = (state == WAIT_WRITE) && data_write_done;
        timed_out  = in_wait && (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) && !last_beat && !write_end;
        state_next = state;
        case (state)
            IDLE:       if (pick_valid) state_next = ISSUE;
            ISSUE:      state_next = is_write ? WAIT_WRITE : WAIT_READ;
            WAIT_READ:  if (last_beat || timed_out) state_next = IDLE;
            WAIT_WRITE: if (write_end || timed_out) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Pointer advances at grant time, so completion and abort treat it identically.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            winner       <= '0;
            is_write     <= 1'b0;
            rr_ptr       <= '0;
            data_address <= '0;
            data_write   <= '0;
            beat_cnt     <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner       <= pick;
                        is_write     <= pick_write;
                        data_address <= pick_address;
                        data_write   <= pick_data;
                    end
                end
                ISSUE: begin
                    rr_ptr   <= (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + PW'(1);
                    beat_cnt <= '0;
                    wait_cnt <= '0;
                end
                WAIT_READ: begin
                    wait_cnt <= wait_cnt + TW'(1);
                    if (data_read_valid) beat_cnt <= beat_cnt + 9'd1;
                end
                default: wait_cnt <= wait_cnt + TW'(1);
            endcase
        end
    end

    always_comb begin
        command              = 2'd0;
        port_grant           = '0;
        port_data_read_valid = '0;
        port_data_write_done = '0;
        port_data_read       = '0;
        timeout_error        = timed_out;
        fsm_state            = state;
        if (state == ISSUE)     command = is_write ? 2'd1 : 2'd2;
        if (state == WAIT_READ) port_data_read = data_read;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (winner == PW'(j)) begin
                port_grant[j]           = (state == ISSUE);
                port_data_read_valid[j] = (state == WAIT_READ) && data_read_valid;
                port_data_write_done[j] = write_end;
            end
        end
    end
endmodule
